// File: rtl/deposit_vend_fsm_if.sv
// Coin-acceptor / dispenser / change-hopper handshake bundle for deposit_vend_fsm.
interface deposit_vend_fsm_if #(
    parameter int CREDIT_W = 7
);
    logic                enable;
    logic [1:0]          coin_in;
    logic                cancel;
    logic                dispense_ack;
    logic [CREDIT_W-1:0] credit;
    logic                dispense_req;
    logic [1:0]          change_coin;
    logic                busy;
    logic [1:0]          state;

    modport master (
        output enable, coin_in, cancel, dispense_ack,
        input  credit, dispense_req, change_coin, busy, state
    );

    modport slave (
        input  enable, coin_in, cancel, dispense_ack,
        output credit, dispense_req, change_coin, busy, state
    );
endinterface

// File: rtl/deposit_vend_fsm.sv
// Price-agnostic coin-deposit controller: collect, handshaked vend, greedy change return.
// Optional refund-on-cancel path is enabled by defining DEPOSIT_REFUND_EN.
module deposit_vend_fsm #(
    parameter int PRICE    = 60,
    parameter int CREDIT_W = 7
) (
    input logic              clock,
    input logic              reset,
    deposit_vend_fsm_if.slave bus
);
    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_VEND    = 2'd1;
    localparam logic [1:0] S_CHANGE  = 2'd2;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    logic [1:0]          state_q, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [CREDIT_W-1:0] sum_c, rem_c, chg_val_c;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] coin);
        case (coin)
            2'b01:   coin_value = CREDIT_W'(5);
            2'b10:   coin_value = CREDIT_W'(10);
            2'b11:   coin_value = CREDIT_W'(25);
            default: coin_value = '0;
        endcase
    endfunction

    // Greedy pick; anything below a dime is paid out as a nickel.
    function automatic logic [1:0] change_pick(input logic [CREDIT_W-1:0] amount);
        if (amount >= CREDIT_W'(25))      change_pick = 2'b11;
        else if (amount >= CREDIT_W'(10)) change_pick = 2'b10;
        else                              change_pick = 2'b01;
    endfunction

`ifndef DEPOSIT_REFUND_EN
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_COLLECT;
            credit_q <= '0;
        end else begin
            state_q  <= state_nxt;
            credit_q <= credit_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        credit_nxt = credit_q;
        sum_c      = credit_q + (bus.enable ? coin_value(bus.coin_in) : '0);
        rem_c      = credit_q - PRICE_C;
        chg_val_c  = coin_value(change_pick(credit_q));
        case (state_q)
            S_COLLECT: begin
                credit_nxt = sum_c;
`ifdef DEPOSIT_REFUND_EN
                if (bus.cancel && (sum_c != '0))
                    state_nxt = S_CHANGE;
                else if (sum_c >= PRICE_C)
                    state_nxt = S_VEND;
`else
                if (sum_c >= PRICE_C)
                    state_nxt = S_VEND;
`endif
            end
            S_VEND: begin
                if (bus.dispense_ack) begin
                    credit_nxt = rem_c;
                    state_nxt  = (rem_c != '0) ? S_CHANGE : S_COLLECT;
                end
            end
            S_CHANGE: begin
                // Last coin (or a stray zero credit) closes out the payout.
                if (credit_q <= chg_val_c) begin
                    credit_nxt = '0;
                    state_nxt  = S_COLLECT;
                end else begin
                    credit_nxt = credit_q - chg_val_c;
                end
            end
            default: begin
                state_nxt  = S_COLLECT;
                credit_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.credit       = credit_q;
        bus.state        = state_q;
        bus.dispense_req = (state_q == S_VEND);
        bus.busy         = (state_q != S_COLLECT);
        bus.change_coin  = (state_q == S_CHANGE) ? change_pick(credit_q) : 2'b00;
    end
endmodule

// File: doc/deposit_vend_fsm.md
# deposit_vend_fsm

Parametrised coin-deposit controller for the vending machine datapath. It accumulates nickel, dime and quarter deposits against a configurable price, and raises a dispense request held until acknowledged. It then returns any overpayment as a sequence of single-cycle coin pulses, largest coin first. It sits between the coin acceptor front end and the product dispenser / change hopper, and generalises the fixed 60-cent deposit tracker into a price-agnostic, handshaked block with change return.

## Interface
- `PRICE`, default 60: vend price in cents. Must be a multiple of 5 and at least 5.
- `CREDIT_W`, default 7: credit register width. Must satisfy `PRICE + 20 <= 2^CREDIT_W - 1`.
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: coin sampling qualifier.
- `coin_in`, input, 2: deposited coin. `00` = none, `01` = nickel (5), `10` = dime (10), `11` = quarter (25).
- `cancel`, input, 1: refund request. Only active with `DEPOSIT_REFUND_EN`.
- `dispense_ack`, input, 1: dispenser has taken the vend.
- `credit`, output, CREDIT_W: current credit in cents.
- `dispense_req`, output, 1: vend request.
- `change_coin`, output, 2: returned coin, same encoding as `coin_in`. `00` when idle.
- `busy`, output, 1: high when the state is not COLLECT.
- `state`, output, 2: FSM state, for debug.

## Operation
- States:
  - COLLECT = 0
  - VEND = 1
  - CHANGE = 2
  - Encoding 3 is illegal and recovers to COLLECT with `credit` cleared on the next edge.
- COLLECT:
  - A coin is accepted when `enable` = 1 and `coin_in` != 00. `credit <= credit + value`.
  - If the new credit is >= PRICE, the next state is VEND; otherwise remain in COLLECT.
  - `coin_in` is ignored when `enable` = 0, and in every other state (`busy` = 1).
- VEND:
  - `dispense_req` = 1 and is held until `dispense_ack` is sampled high.
  - On ack: `credit <= credit - PRICE`. Go to CHANGE if the remainder is nonzero, else to COLLECT.
  - `dispense_ack` is ignored in the other states.
- CHANGE:
  - `change_coin` is the largest coin <= `credit`: quarter if >= 25, else dime if >= 10, else nickel.
  - Each edge subtracts that coin's value from `credit`. When `credit` reaches 0, go to COLLECT.
  - One coin is emitted per cycle, with no stall input.
- All outputs are Moore outputs, decoded from the registered `state` and `credit`.
- Arithmetic is unsigned. The parameter constraint guarantees no overflow, since the maximum credit is `PRICE - 5 + 25`.
- Reset at any point:
  - `credit` = 0, `state` = COLLECT, `dispense_req` = 0, `change_coin` = 00, `busy` = 0.
  - A pending vend or undelivered change is discarded.

## Timing
- A coin sampled at edge N is visible on `credit` after edge N.
- If that coin reaches PRICE, `dispense_req` rises in the cycle after edge N.
- `dispense_ack` sampled at edge M:
  - `dispense_req` falls after M.
  - The first `change_coin` pulse is present in the cycle after M.
- Change for remainder R takes k cycles, where k is the number of coins in the greedy decomposition of R. Example: R = 20 gives two cycles, dime then dime.
- The first coin can be accepted on the edge that ends the last CHANGE cycle plus one, i.e. once `state` = COLLECT is visible.
- `dispense_ack` held high continuously counts once; the FSM leaves VEND on the first sampled high.

## Configuration
- `DEPOSIT_REFUND_EN` defined:
  - In COLLECT, `cancel` = 1 with a resulting credit > 0 moves the FSM to CHANGE and returns all credit.
  - A coin sampled on the same edge as `cancel` is added first, then refunded. VEND is not entered even if the sum is >= PRICE.
  - `cancel` with zero credit and no coin has no effect.
  - `cancel` in VEND or CHANGE is ignored.
- `DEPOSIT_REFUND_EN` undefined:
  - The `cancel` port is present but unused.
  - Credit is only released by a vend.

## Test plan
- Reset, then 12 nickels with `enable` = 1 → `credit` reaches 60 → `dispense_req` = 1. Ack → back to COLLECT with `credit` = 0 and no `change_coin` pulses.
- 55 cents deposited, then a quarter → `credit` = 80, VEND. Ack → `change_coin` = dime, dime on two consecutive cycles, then COLLECT with `credit` = 0.
- Quarter with `enable` = 0, and a coin during VEND → `credit` unchanged both times.
- `dispense_ack` delayed 5 cycles → `dispense_req` is held for all 5 cycles and `credit` stays at 60+.
- With `DEPOSIT_REFUND_EN`, 35 cents then `cancel` together with a quarter → CHANGE, then quarter, quarter, dime, with no `dispense_req`. Without the macro, the same stimulus gives VEND with `credit` = 60.
- Synchronous `reset` asserted mid-CHANGE with 15 cents remaining → next cycle `credit` = 0, `change_coin` = 00, `state` = 0.
